// File: rtl/mem_stage.sv
// mem_stage: MIPS pipeline memory stage, downstream of exe_stage.
// Latches EXE results, aligns/extends loads, merges LWL/LWR, drives WB.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ws_allowin / ms_allowin    WB->MEM and MEM->EXE flow control
//   es_to_ms_valid/_bus        EXE instruction and payload
//   es_load_mem_bus            {width[1:0], signed, lr[1:0], addr[1:0]}
//   es_ex_bus                  EXE exception / CP0 info
//   es_sram_rdata, es_rt_value load word read in EXE, old rt value
//   ms_to_ws_valid/_bus        WB instruction and payload
//   ms_ex_bus                  registered exception bus to WB
//   ms_write_reg, ms_reg_dest  hazard detection for ID
//   ms_to_ds_bus               final result forwarded to ID
//   ms_mfc0_stall, ms_ex       MFC0 stall and exception indication
//   flush                      CP0 exception/ERET flush
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 71,
    parameter int ES_EX_BUS_WD    = 47,
    parameter int MS_TO_WS_BUS_WD = 70
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic [6:0]                 es_load_mem_bus,
    input  logic [ES_EX_BUS_WD-1:0]    es_ex_bus,
    input  logic [31:0]                es_sram_rdata,
    input  logic [31:0]                es_rt_value,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [ES_EX_BUS_WD-1:0]    ms_ex_bus,
    output logic                       ms_write_reg,
    output logic [4:0]                 ms_reg_dest,
    output logic [31:0]                ms_to_ds_bus,
    output logic                       ms_mfc0_stall,
    output logic                       ms_ex,
    input  logic                       flush
);

    logic                       ms_valid;
    logic                       ms_ready_go;
    logic [ES_TO_MS_BUS_WD-1:0] es_bus_r;
    logic [6:0]                 ld_bus_r;
    logic [ES_EX_BUS_WD-1:0]    ex_bus_r;
    logic [31:0]                rdata_r;
    logic [31:0]                rt_r;

    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;

    logic [1:0]  ld_width;
    logic        ld_signed;
    logic [1:0]  ld_lr;
    logic [1:0]  ld_addr;

    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] lwl_word;
    logic [31:0] lwr_word;
    logic [31:0] load_result;
    logic [31:0] final_result;

    // The access already completed in EXE, so MEM never stalls itself.
    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            ms_valid <= 1'b0;
            es_bus_r <= '0;
            ld_bus_r <= '0;
            ex_bus_r <= '0;
            rdata_r  <= '0;
            rt_r     <= '0;
        end else begin
            if (ms_allowin) begin
                ms_valid <= es_to_ms_valid;
            end
            if (es_to_ms_valid && ms_allowin) begin
                es_bus_r <= es_to_ms_bus;
                ld_bus_r <= es_load_mem_bus;
                ex_bus_r <= es_ex_bus;
                rdata_r  <= es_sram_rdata;
                rt_r     <= es_rt_value;
            end
        end
    end

    assign {res_from_mem, gr_we, dest, alu_result, pc} = es_bus_r;
    assign {ld_width, ld_signed, ld_lr, ld_addr}       = ld_bus_r;

    always_comb begin
        load_byte = 8'h00;
        lwl_word  = rdata_r;
        lwr_word  = rdata_r;
        unique case (ld_addr)
            2'b00: begin
                load_byte = rdata_r[7:0];
                lwl_word  = {rdata_r[7:0], rt_r[23:0]};
                lwr_word  = rdata_r;
            end
            2'b01: begin
                load_byte = rdata_r[15:8];
                lwl_word  = {rdata_r[15:0], rt_r[15:0]};
                lwr_word  = {rt_r[31:24], rdata_r[31:8]};
            end
            2'b10: begin
                load_byte = rdata_r[23:16];
                lwl_word  = {rdata_r[23:0], rt_r[7:0]};
                lwr_word  = {rt_r[31:16], rdata_r[31:16]};
            end
            default: begin
                load_byte = rdata_r[31:24];
                lwl_word  = rdata_r;
                lwr_word  = {rt_r[31:8], rdata_r[31:24]};
            end
        endcase
    end

    assign load_half = ld_addr[1] ? rdata_r[31:16] : rdata_r[15:0];

    always_comb begin
        load_result = rdata_r;
        unique case (ld_width)
            2'b11: load_result = rdata_r;
            2'b10: load_result = {{16{ld_signed & load_half[15]}},
                                  load_half};
            2'b01: load_result = {{24{ld_signed & load_byte[7]}},
                                  load_byte};
            default: begin
                // Partial-word loads; other lr codes fall back to rdata.
                unique case (ld_lr)
                    2'b10:   load_result = lwl_word;
                    2'b01:   load_result = lwr_word;
                    default: load_result = rdata_r;
                endcase
            end
        endcase
    end

    assign final_result = res_from_mem ? load_result : alu_result;

    // ex bus bits: 45 sys, 42 eret, 41 break, 40 ov, 39 adel, 38 ades, 37 ri
    assign ms_ex = ms_valid && (ex_bus_r[45] || ex_bus_r[42] ||
                                ex_bus_r[41] || ex_bus_r[40] ||
                                ex_bus_r[39] || ex_bus_r[38] ||
                                ex_bus_r[37]);

    assign ms_write_reg  = gr_we && ms_valid && !ms_ex;
    assign ms_reg_dest   = dest;
    assign ms_to_ds_bus  = final_result;
    assign ms_mfc0_stall = ex_bus_r[44] && ms_valid;
    assign ms_ex_bus     = ex_bus_r;
    assign ms_to_ws_bus  = {gr_we & ~ms_ex, dest, final_result, pc};

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: scoreboard bench for mem_stage.
// Expected WB payloads are queued when EXE drives, compared on transfer.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [70:0] es_to_ms_bus;
    logic [6:0]  es_load_mem_bus;
    logic [46:0] es_ex_bus;
    logic [31:0] es_sram_rdata;
    logic [31:0] es_rt_value;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [46:0] ms_ex_bus;
    logic        ms_write_reg;
    logic [4:0]  ms_reg_dest;
    logic [31:0] ms_to_ds_bus;
    logic        ms_mfc0_stall;
    logic        ms_ex;
    logic        flush;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [69:0] bus;
        logic [46:0] ex;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    exp_t hold_e;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .es_load_mem_bus (es_load_mem_bus),
        .es_ex_bus       (es_ex_bus),
        .es_sram_rdata   (es_sram_rdata),
        .es_rt_value     (es_rt_value),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .ms_ex_bus       (ms_ex_bus),
        .ms_write_reg    (ms_write_reg),
        .ms_reg_dest     (ms_reg_dest),
        .ms_to_ds_bus    (ms_to_ds_bus),
        .ms_mfc0_stall   (ms_mfc0_stall),
        .ms_ex           (ms_ex),
        .flush           (flush)
    );

    task automatic chk(input string tag, input logic [69:0] got,
                       input logic [69:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] load_model(input logic [6:0] lb,
                                               input logic [31:0] r,
                                               input logic [31:0] t);
        int          sh;
        logic [31:0] ones;
        logic [31:0] s;
        logic [31:0] m;
        logic [15:0] h;
        logic [7:0]  b;
        ones = '1;
        sh   = 8 * int'(lb[1:0]);
        s    = r >> sh;
        b    = s[7:0];
        s    = r >> (lb[1] ? 16 : 0);
        h    = s[15:0];
        case (lb[6:5])
            2'b11: return r;
            2'b10: return lb[4] ? 32'($signed(h)) : {16'h0, h};
            2'b01: return lb[4] ? 32'($signed(b)) : {24'h0, b};
            default: begin
                if (lb[3:2] == 2'b10) begin
                    m = ones >> (sh + 8);
                    return (r << (24 - sh)) | (t & m);
                end
                m = ~(ones >> sh);
                return (r >> sh) | (t & m);
            end
        endcase
    endfunction

    task automatic set_in(input bit rfm, input bit we,
                          input logic [4:0] d, input logic [31:0] alu,
                          input logic [31:0] pc, input logic [6:0] lb,
                          input logic [46:0] ex, input logic [31:0] r,
                          input logic [31:0] t);
        es_to_ms_valid  = 1'b1;
        es_to_ms_bus    = {rfm, we, d, alu, pc};
        es_load_mem_bus = lb;
        es_ex_bus       = ex;
        es_sram_rdata   = r;
        es_rt_value     = t;
    endtask

    task automatic push_exp(output exp_t e);
        logic        exc;
        logic [31:0] res;
        logic [46:0] ex;
        ex  = es_ex_bus;
        exc = ex[45] | ex[42] | ex[41] | ex[40] | ex[39] | ex[38] | ex[37];
        res = es_to_ms_bus[70]
            ? load_model(es_load_mem_bus, es_sram_rdata, es_rt_value)
            : es_to_ms_bus[63:32];
        e.bus = {es_to_ms_bus[69] & ~exc, es_to_ms_bus[68:64],
                 res, es_to_ms_bus[31:0]};
        e.ex  = ex;
        sbq.push_back(e);
    endtask

    // Called at posedge+1; returns at posedge+1 after the capture edge.
    task automatic accept(input bit rnd);
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (rnd) ws_allowin = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            ok = ms_allowin;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        if (!ok) chk("accept_timeout", 0, 1);
        es_to_ms_valid = 1'b0;
    endtask

    task automatic load_test(input string tag, input logic [6:0] lb,
                             input logic [31:0] r, input logic [31:0] t,
                             input logic [31:0] exp);
        exp_t e;
        set_in(1'b1, 1'b1, 5'd3, 32'hDEAD_0000, 32'hBFC0_0100,
               lb, 47'h0, r, t);
        push_exp(e);
        accept(1'b0);
        @(negedge clk);
        chk(tag, ms_to_ds_bus, exp);
        chk({tag, "_wr"}, ms_write_reg, 1);
        chk({tag, "_dest"}, ms_reg_dest, 3);
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!reset && !flush && ms_to_ws_valid && ws_allowin) begin
            if (sbq.size() == 0) begin
                chk("sb_extra", 1, 0);
            end else begin
                mon_e = sbq.pop_front();
                chk("sb_bus", ms_to_ws_bus, mon_e.bus);
                chk("sb_ex", ms_ex_bus, mon_e.ex);
            end
        end
    end

    initial begin
        logic [46:0] ex;
        logic [6:0]  lb;
        logic [1:0]  w;
        exp_t        e;

        reset           = 1'b1;
        flush           = 1'b0;
        ws_allowin      = 1'b1;
        es_to_ms_valid  = 1'b0;
        es_to_ms_bus    = '0;
        es_load_mem_bus = '0;
        es_ex_bus       = '0;
        es_sram_rdata   = '0;
        es_rt_value     = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        chk("rst_allowin", ms_allowin, 1);
        chk("rst_valid", ms_to_ws_valid, 0);
        chk("rst_bus", ms_to_ws_bus, 0);
        chk("rst_ex_bus", ms_ex_bus, 0);
        chk("rst_wr", ms_write_reg, 0);
        chk("rst_dest", ms_reg_dest, 0);
        chk("rst_ds", ms_to_ds_bus, 0);
        chk("rst_stall", ms_mfc0_stall, 0);
        chk("rst_ex", ms_ex, 0);
        @(posedge clk);
        #1;

        load_test("lb", 7'b01_1_00_01, 32'h8081_8283, 0, 32'hFFFF_FF82);
        load_test("lbu", 7'b01_0_00_01, 32'h8081_8283, 0, 32'h0000_0082);
        load_test("lh", 7'b10_1_00_10, 32'h8000_1234, 0, 32'hFFFF_8000);
        load_test("lhu", 7'b10_0_00_00, 32'h8000_1234, 0, 32'h0000_1234);
        load_test("lwl", 7'b00_0_10_01, 32'hAABB_CCDD, 32'h1122_3344,
                  32'hCCDD_3344);
        load_test("lwr", 7'b00_0_01_10, 32'hAABB_CCDD, 32'h1122_3344,
                  32'h1122_AABB);
        load_test("lw", 7'b11_0_00_00, 32'h1357_9BDF, 0, 32'h1357_9BDF);

        // Backpressure: A held while WB stalls, B waits in EXE.
        set_in(1'b0, 1'b1, 5'd4, 32'h0000_00A0, 32'h0000_1000,
               7'h0, 47'h0, 0, 0);
        push_exp(hold_e);
        accept(1'b0);
        ws_allowin = 1'b0;
        set_in(1'b0, 1'b1, 5'd5, 32'h0000_00B0, 32'h0000_1004,
               7'h0, 47'h0, 0, 0);
        push_exp(e);
        repeat (3) begin
            @(negedge clk);
            chk("bp_allowin", ms_allowin, 0);
            chk("bp_valid", ms_to_ws_valid, 1);
            chk("bp_bus", ms_to_ws_bus, hold_e.bus);
            @(posedge clk);
            #1;
        end
        ws_allowin = 1'b1;
        @(negedge clk);
        chk("bp_release", ms_allowin, 1);
        @(posedge clk);
        #1;
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        chk("bp_next_valid", ms_to_ws_valid, 1);
        chk("bp_next_dest", ms_reg_dest, 5);
        @(posedge clk);
        #1;

        // Flush in the capture cycle drops the instruction.
        ex = '0;
        ex[38] = 1'b1;
        ex[31:0] = 32'h0000_0003;
        set_in(1'b1, 1'b1, 5'd6, 32'h1234_5678, 32'h0000_2000,
               7'b11_0_00_00, ex, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        es_to_ms_valid = 1'b0;
        @(negedge clk);
        chk("fl_valid", ms_to_ws_valid, 0);
        chk("fl_bus", ms_to_ws_bus, 0);
        chk("fl_ex_bus", ms_ex_bus, 0);
        chk("fl_wr", ms_write_reg, 0);
        chk("fl_allowin", ms_allowin, 1);
        @(posedge clk);
        #1;

        // Address-error store with gr_we set must not write.
        ex = '0;
        ex[38] = 1'b1;
        ex[31:0] = 32'h0000_0101;
        set_in(1'b0, 1'b1, 5'd7, 32'h0000_0101, 32'h0000_3000,
               7'h0, ex, 0, 0);
        push_exp(e);
        accept(1'b0);
        @(negedge clk);
        chk("ex_flag", ms_ex, 1);
        chk("ex_wr", ms_write_reg, 0);
        chk("ex_bus_we", ms_to_ws_bus[69], 0);
        chk("ex_pass", ms_ex_bus, ex);
        @(posedge clk);
        #1;

        // MFC0 stalls ID until it leaves MEM.
        ex = '0;
        ex[44] = 1'b1;
        ex[36:32] = 5'd12;
        ws_allowin = 1'b0;
        set_in(1'b0, 1'b1, 5'd9, 32'h0000_0000, 32'h0000_4000,
               7'h0, ex, 0, 0);
        push_exp(e);
        accept(1'b0);
        repeat (2) begin
            @(negedge clk);
            chk("mfc0_stall", ms_mfc0_stall, 1);
            @(posedge clk);
            #1;
        end
        ws_allowin = 1'b1;
        @(negedge clk);
        chk("mfc0_stall_last", ms_mfc0_stall, 1);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("mfc0_stall_gone", ms_mfc0_stall, 0);
        @(posedge clk);
        #1;

        // Random traffic with random WB backpressure.
        for (int i = 0; i < 60; i++) begin
            w = 2'($urandom_range(0, 3));
            lb = {w, 1'($urandom), 2'($urandom), 2'($urandom)};
            if (w == 2'b00) lb[3:2] = $urandom_range(0, 1) ? 2'b10 : 2'b01;
            ex = '0;
            if ($urandom_range(0, 3) == 0) ex = {15'($urandom), 32'($urandom)};
            set_in(1'($urandom), 1'($urandom), 5'($urandom), $urandom,
                   $urandom, lb, ex, $urandom, $urandom);
            push_exp(e);
            accept(1'b1);
        end
        ws_allowin = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("sb_left", 70'(sbq.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
